// File: rtl/key_expand_word.sv
// Iterative AES key-expansion word generator (NK = 4/6/8), one round-key word per handshake.
// Optional macro KEYEXP_EQINV_EN: present middle words as InvMixColumns(w[i]) (equivalent inverse schedule).
module key_expand_word #(
    parameter int NK        = 4,
    parameter int ROT_BYTES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [32*NK-1:0] key,
    input  logic            abort,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_word,
    output logic [5:0]      out_idx,
    output logic            out_last
);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("key_expand_word: NK must be 4, 6 or 8");
    end
    if (ROT_BYTES < 1 || ROT_BYTES > 3) begin : g_bad_rot
        $error("key_expand_word: ROT_BYTES must be 1..3");
    end

    localparam int         NWORDS   = 4 * (NK + 7);
    localparam logic [5:0] LAST_IDX = 6'(NWORDS - 1);
    localparam logic [2:0] PH_MAX   = 3'(NK - 1);
`ifdef KEYEXP_EQINV_EN
    localparam logic [5:0] EQ_LO    = 6'd4;
    localparam logic [5:0] EQ_HI    = 6'(4 * (NK + 6) - 1);
`endif

    // FIPS-197 forward S-box, byte 8'h00 in the MSBs.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        sbox = SBOX_TABLE[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        case (ROT_BYTES)
            1:       rot_word = {w[23:0], w[31:24]};
            2:       rot_word = {w[15:0], w[31:16]};
            3:       rot_word = {w[7:0],  w[31:8]};
            default: rot_word = w;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

`ifdef KEYEXP_EQINV_EN
    function automatic logic [7:0] mul_e(input logic [7:0] b);
        mul_e = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction
    function automatic logic [7:0] mul_b(input logic [7:0] b);
        mul_b = xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction
    function automatic logic [7:0] mul_d(input logic [7:0] b);
        mul_d = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction
    function automatic logic [7:0] mul_9(input logic [7:0] b);
        mul_9 = xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [31:0] inv_mix_columns(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        inv_mix_columns = {mul_e(b0) ^ mul_b(b1) ^ mul_d(b2) ^ mul_9(b3),
                           mul_9(b0) ^ mul_e(b1) ^ mul_b(b2) ^ mul_d(b3),
                           mul_d(b0) ^ mul_9(b1) ^ mul_e(b2) ^ mul_b(b3),
                           mul_b(b0) ^ mul_d(b1) ^ mul_9(b2) ^ mul_e(b3)};
    endfunction
`endif

    state_t      state_r, state_nxt_s;
    logic [31:0] window_r [NK];
    logic [7:0]  rcon_r;
    logic [2:0]  phase_r;
    logic [31:0] out_word_r;
    logic [5:0]  out_idx_r;
    logic        out_valid_r;
    logic        out_last_r;

    logic        xfer_s;
    logic        load_s;
    logic [31:0] temp_s;
    logic [31:0] new_word_s;
    logic [5:0]  nxt_idx_s;
    logic [31:0] nxt_word_s;

    assign xfer_s    = out_valid_r && out_ready;
    assign load_s    = (state_r == IDLE) && start && !abort;
    assign nxt_idx_s = out_idx_r + 6'd1;

    assign busy      = (state_r != IDLE);
    assign out_valid = out_valid_r;
    assign out_word  = out_word_r;
    assign out_idx   = out_idx_r;
    assign out_last  = out_last_r;

    // Window is a look-ahead: window_r[0] = w[out_idx], so the appended word is w[out_idx+NK]
    // and its position mod NK equals phase_r.
    always_comb begin
        temp_s = window_r[NK-1];
        if (phase_r == 3'd0) begin
            temp_s = sub_word(rot_word(window_r[NK-1])) ^ {rcon_r, 24'h000000};
        end else if (NK == 8 && phase_r == 3'd4) begin
            temp_s = sub_word(window_r[NK-1]);
        end else begin
            temp_s = window_r[NK-1];
        end
        new_word_s = window_r[0] ^ temp_s;
    end

    // Presentation of the word that becomes visible after a transfer.
    always_comb begin
        nxt_word_s = window_r[1];
`ifdef KEYEXP_EQINV_EN
        if (nxt_idx_s >= EQ_LO && nxt_idx_s <= EQ_HI) begin
            nxt_word_s = inv_mix_columns(window_r[1]);
        end else begin
            nxt_word_s = window_r[1];
        end
`endif
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        if (abort) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) state_nxt_s = EMIT;
                    else       state_nxt_s = IDLE;
                end
                EMIT: begin
                    if (xfer_s && out_last_r) state_nxt_s = IDLE;
                    else                      state_nxt_s = EMIT;
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Window, round-constant and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NK; j++) window_r[j] <= 32'h0;
            rcon_r      <= 8'h00;
            phase_r     <= 3'd0;
            out_word_r  <= 32'h0;
            out_idx_r   <= 6'd0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (abort) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (load_s) begin
            for (int j = 0; j < NK; j++) window_r[j] <= key[32*(NK-j)-1 -: 32];
            rcon_r      <= 8'h01;
            phase_r     <= 3'd0;
            out_word_r  <= key[32*NK-1 -: 32];
            out_idx_r   <= 6'd0;
            out_valid_r <= 1'b1;
            out_last_r  <= 1'b0;
        end else if (xfer_s) begin
            for (int j = 0; j < NK - 1; j++) window_r[j] <= window_r[j+1];
            window_r[NK-1] <= new_word_s;
            phase_r <= (phase_r == PH_MAX) ? 3'd0 : phase_r + 3'd1;
            if (phase_r == 3'd0) rcon_r <= xtime(rcon_r);
            if (out_last_r) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end else begin
                out_word_r <= nxt_word_s;
                out_idx_r  <= nxt_idx_s;
                out_last_r <= (nxt_idx_s == LAST_IDX);
            end
        end
    end

endmodule

// File: tb/tb_key_expand_word.sv
// Directed bench for key_expand_word: NK=4/6/8 FIPS-197 vectors, stalls, abort, mid-stream reset.
module tb_key_expand_word;

`ifdef KEYEXP_EQINV_EN
    localparam bit EQ_EN = 1'b1;
`else
    localparam bit EQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic        st [3];
    logic        by [3];
    logic        ov [3];
    logic        ol [3];
    logic [31:0] ow [3];
    logic [5:0]  oi [3];
    logic [255:0] keyv [3];

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]  sb [256];
    logic [31:0] mw [60];
    logic [31:0] got [60];

    always #5 clk = ~clk;

    key_expand_word #(.NK(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(st[0]), .key(keyv[0][255:128]),
        .abort(abort), .busy(by[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_word(ow[0]),
        .out_idx(oi[0]), .out_last(ol[0]));
    key_expand_word #(.NK(6)) dut6 (.clk(clk), .rst_n(rst_n), .start(st[1]), .key(keyv[1][255:64]),
        .abort(abort), .busy(by[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_word(ow[1]),
        .out_idx(oi[1]), .out_last(ol[1]));
    key_expand_word #(.NK(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(st[2]), .key(keyv[2]),
        .abort(abort), .busy(by[2]), .out_valid(ov[2]), .out_ready(out_ready), .out_word(ow[2]),
        .out_idx(oi[2]), .out_last(ol[2]));

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl8(input logic [7:0] b, input int k);
        logic [15:0] t;
        t = {b, b} << k;
        return t[15:8];
    endfunction

    // S-box from the GF(2^8) inverse and affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rl8(inv, 1) ^ rl8(inv, 2) ^ rl8(inv, 3) ^ rl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    function automatic logic [31:0] invmix(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        return {gm(b0,8'h0e) ^ gm(b1,8'h0b) ^ gm(b2,8'h0d) ^ gm(b3,8'h09),
                gm(b0,8'h09) ^ gm(b1,8'h0e) ^ gm(b2,8'h0b) ^ gm(b3,8'h0d),
                gm(b0,8'h0d) ^ gm(b1,8'h09) ^ gm(b2,8'h0e) ^ gm(b3,8'h0b),
                gm(b0,8'h0b) ^ gm(b1,8'h0d) ^ gm(b2,8'h09) ^ gm(b3,8'h0e)};
    endfunction

    function automatic logic [31:0] xform(input int n, input int idx, input logic [31:0] w);
        if (EQ_EN && idx >= 4 && idx <= 4 * (n + 6) - 1) return invmix(w);
        return w;
    endfunction

    task automatic build_model(input int d);
        int n;
        logic [7:0]  rc;
        logic [31:0] t;
        n = 4 + 2 * d;
        rc = 8'h01;
        for (int i = 0; i < 4 * (n + 7); i++) begin
            if (i < n) begin
                mw[i] = keyv[d][255 - 32 * i -: 32];
            end else begin
                t = mw[i-1];
                if (i % n == 0) begin
                    t = sw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = gm(rc, 8'h02);
                end else if (n == 8 && i % n == 4) begin
                    t = sw(t);
                end
                mw[i] = mw[i-n] ^ t;
            end
        end
    endtask

    // mode 0: run to completion (start asserted alongside the final transfer in directed mode),
    // mode 1: abort at stop_at, mode 2: reset at stop_at.
    task automatic run_stream(input int d, input bit rnd, input int mode, input int stop_at);
        int n, total, cnt, cyc;
        bit done;
        logic [31:0] ew;
        n = 4 + 2 * d;
        total = 4 * (n + 7);
        build_model(d);
        @(negedge clk); st[d] = 1'b1; out_ready = 1'b1;
        @(negedge clk); st[d] = 1'b0;
        cnt = 0; cyc = 0; done = 1'b0;
        while (!done && cnt < total && cyc < 1000) begin
            ew = xform(n, cnt, mw[cnt]);
            n_cmp++;
            if (ov[d] !== 1'b1 || by[d] !== 1'b1 || oi[d] !== 6'(cnt) || ow[d] !== ew ||
                ol[d] !== (cnt == total - 1)) begin
                n_err++;
                $display("FAIL word nk=%0d: got v=%b busy=%b idx=%0d w=%h last=%b, want idx=%0d w=%h last=%b",
                         n, ov[d], by[d], oi[d], ow[d], ol[d], cnt, ew, (cnt == total - 1));
            end
            got[cnt] = ow[d];
            if (mode != 0 && cnt == stop_at) begin
                done = 1'b1;
                st[d] = 1'b0;
                if (mode == 1) begin
                    abort = 1'b1; out_ready = 1'b1;
                    @(negedge clk); abort = 1'b0;
                    n_cmp++;
                    if (by[d] !== 1'b0 || ov[d] !== 1'b0 || ol[d] !== 1'b0) begin
                        n_err++;
                        $display("FAIL abort_idle: got busy=%b v=%b last=%b, want 0 0 0", by[d], ov[d], ol[d]);
                    end
                    st[d] = 1'b1;
                    @(negedge clk); st[d] = 1'b0;
                    n_cmp++;
                    if (ov[d] !== 1'b1 || by[d] !== 1'b1 || oi[d] !== 6'd0 || ow[d] !== mw[0]) begin
                        n_err++;
                        $display("FAIL restart: got v=%b busy=%b idx=%0d w=%h, want 1 1 0 %h",
                                 ov[d], by[d], oi[d], ow[d], mw[0]);
                    end
                    abort = 1'b1;
                    @(negedge clk); abort = 1'b0;
                end else begin
                    rst_n = 1'b0;
                    #1;
                    n_cmp++;
                    if (by[d] !== 1'b0 || ov[d] !== 1'b0 || ol[d] !== 1'b0 || ow[d] !== 32'h0 || oi[d] !== 6'd0) begin
                        n_err++;
                        $display("FAIL reset_mid: got busy=%b v=%b last=%b w=%h idx=%0d, want all 0",
                                 by[d], ov[d], ol[d], ow[d], oi[d]);
                    end
                    @(negedge clk); rst_n = 1'b1;
                    @(negedge clk);
                    n_cmp++;
                    if (ov[d] !== 1'b0 || by[d] !== 1'b0) begin
                        n_err++;
                        $display("FAIL reset_release: got v=%b busy=%b, want 0 0", ov[d], by[d]);
                    end
                end
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                st[d] = rnd ? 1'($urandom_range(0, 1)) : (cnt == total - 1);
                if (out_ready) cnt++;
                @(negedge clk);
                cyc++;
            end
        end
        n_cmp++;
        if (mode == 0) begin
            if (cnt != total || by[d] !== 1'b0 || ov[d] !== 1'b0 || ol[d] !== 1'b0) begin
                n_err++;
                $display("FAIL end nk=%0d: got words=%0d busy=%b v=%b last=%b, want %0d 0 0 0",
                         n, cnt, by[d], ov[d], ol[d], total);
            end
        end else if (!done) begin
            n_err++;
            $display("FAIL stop_point nk=%0d: got idx %0d after %0d cycles, want idx %0d", n, cnt, cyc, stop_at);
        end
        st[d] = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic hand_check(input int n, input int idx, input logic [31:0] raw);
        logic [31:0] e;
        e = xform(n, idx, raw);
        n_cmp++;
        if (got[idx] !== e) begin
            n_err++;
            $display("FAIL vector nk=%0d w[%0d]: got %h, want %h", n, idx, got[idx], e);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (by[d] !== 1'b0 || ov[d] !== 1'b0 || ol[d] !== 1'b0 || ow[d] !== 32'h0 || oi[d] !== 6'd0) begin
                n_err++;
                $display("FAIL reset dut%0d: got busy=%b v=%b last=%b w=%h idx=%0d, want all 0",
                         d, by[d], ov[d], ol[d], ow[d], oi[d]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nk4();
        run_stream(0, 1'b0, 0, 0);
        hand_check(4, 4, 32'ha0fafe17);
        hand_check(4, 43, 32'hb6630ca6);
    endtask

    task automatic test_nk6();
        run_stream(1, 1'b0, 0, 0);
        hand_check(6, 6, 32'hfe0c91f7);
        hand_check(6, 51, 32'h01002202);
    endtask

    task automatic test_nk8();
        run_stream(2, 1'b0, 0, 0);
        hand_check(8, 8, 32'h9ba35411);
        hand_check(8, 12, 32'ha8b09c1a);
        hand_check(8, 59, 32'h706c631e);
    endtask

    task automatic test_stall_abort();
        run_stream(0, 1'b1, 1, 20);
        run_stream(0, 1'b1, 0, 0);
    endtask

    task automatic test_reset_mid();
        run_stream(0, 1'b1, 2, 30);
        run_stream(0, 1'b0, 0, 0);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) st[d] = 1'b0;
        keyv[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        keyv[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        keyv[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        build_sbox();
        test_reset();
        test_nk4();
        test_nk6();
        test_nk8();
        test_stall_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/key_expand_word.md
Name: key_expand_word

Overview:
- Iterative AES key-expansion word generator, parametrised for AES-128/192/256 (NK = 4/6/8).
- Successor to the fixed combinational rotate: applies RotWord, SubWord and Rcon internally and streams all 4*(NK+7) round-key words, one per accepted handshake.
- Sits between the key register and the decryption core's round-key store.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4, 6, 8; any other value is an elaboration error.
- ROT_BYTES, 1, left byte-rotation applied in RotWord; legal 1..3; AES-compliant value is 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  load key and begin expansion; honoured only in IDLE
- key  in  32*NK  cipher key; w[0] in MSBs, byte 0 of each word in its MSBs
- abort  in  1  synchronous return to IDLE
- busy  out  1  high in any state other than IDLE
- out_valid  out  1  out_word holds a valid word
- out_ready  in  1  consumer accepts the word
- out_word  out  32  w[out_idx]
- out_idx  out  6  word index 0 .. 4*(NK+7)-1
- out_last  out  1  high with the final word (index 43/51/59)

Behaviour:
- Reset: state=IDLE; busy, out_valid, out_last, out_word, out_idx, window and rcon all 0.
- States:
  - IDLE -> EMIT on start.
  - EMIT -> EMIT on a handshake with !out_last.
  - EMIT -> IDLE on a handshake with out_last.
  - Any state -> IDLE on abort.
- Latency: start sampled at edge t; out_valid=1 with w[0] (out_idx=0) after edge t.
- Handshake:
  - A word transfers on an edge where out_valid && out_ready.
  - While stalled, out_word, out_idx and out_last hold stable and no state advances.
  - start while busy is ignored.
- Window: NK-word shift register, loaded from key on start. On each transfer it shifts by one word and appends the newly computed word.
- Word generation, for i = out_idx+1 after a transfer:
  - If i < NK: w[i] = key word i.
  - Else, with temp = w[i-1]:
    - if i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}
    - else if NK == 8 and i mod NK == 4: temp = SubWord(temp)
  - w[i] = w[i-NK] ^ temp.
- Arithmetic and counters:
  - i mod NK is tracked with a wrap counter (no divider).
  - rcon starts at 8'h01 and advances by xtime after each use, giving 01,02,04,08,10,20,40,80,1b,36.
- SubWord: four parallel combinational FIPS-197 S-box lookups.
- Single-cycle path: next word is registered in the same cycle as the transfer, so back-to-back transfers sustain 1 word/clk.
- Boundaries:
  - out_last transfer: out_valid drops on the next edge; busy drops together with it.
  - start in the same cycle as the final transfer is ignored (state still EMIT).
  - abort and a transfer in the same cycle: abort wins; the word counts as consumed, then the block idles.
  - rst_n low mid-expansion clears everything asynchronously; no partial word is presented after release.

Optional Feature:
- KEYEXP_EQINV_EN defined: out_word for indices 4 .. 4*(NK+6)-1 is InvMixColumns(w[i]), the equivalent inverse cipher key schedule.
  - First 4 and last 4 words pass unmodified.
  - Internal window always holds the raw w[i].
  - Transform is one combinational stage on the output register input; latency is unchanged.
- Undefined: out_word = w[i] for all i.

Test Plan:
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, out_ready=1 -> 44 words on consecutive cycles; w[4]=a0fafe17, w[43]=b6630ca6 with out_last=1, then busy=0.
- NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w[6]=fe0c91f7, w[51]=01002202, exactly 52 words.
- NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> w[8]=9ba35411, w[12]=a8b09c1a (SubWord-only step), w[59]=706c631e.
- NK=4, out_ready toggled pseudo-randomly, start pulsed while busy, abort at idx 20 -> stalled outputs stable; start ignored; idle next cycle; fresh start restarts at idx 0.
- rst_n asserted at idx 30 -> all outputs 0 immediately; after release with start, the sequence repeats from w[0] bit-exact.
- KEYEXP_EQINV_EN, NK=4 -> idx 0-3 and 40-43 raw; idx 4-39 equal InvMixColumns of raw words from the reference model.
